// File: rtl/im_boot_loader_if.sv
// im_boot_loader_if: byte-stream input and instruction-memory write port of the boot loader
interface im_boot_loader_if #(
  parameter int AW = 10
);
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  modport master (input rx_valid, rx_data, output rx_ready, im_we, im_addr, im_wdata);
  modport slave (output rx_valid, rx_data, input rx_ready, im_we, im_addr, im_wdata);
endinterface

// File: rtl/im_boot_loader.sv
// im_boot_loader: loads a length-prefixed byte image into instruction memory, then releases CPU reset; LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
module im_boot_loader #(
  parameter int AW      = 10,
  parameter int TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  im_boot_loader_if.master bus,
  output logic             cpu_rstn,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int DEPTH = 1 << AW;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA,
`ifdef LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE, ERR
  } state_t;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t FIN = CHK;
`else
  localparam state_t FIN = DONE;
`endif
  state_t        state, nxt;
  logic [15:0]   len, wcnt, n;
  logic [1:0]    bidx;
  logic [23:0]   sh;
  logic [TW-1:0] to_cnt;
  logic          acc, tout, last;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif
  function automatic logic rcv(state_t s);
`ifdef LOADER_CHECKSUM_EN
    return s == LEN0 || s == LEN1 || s == DATA || s == CHK;
`else
    return s == LEN0 || s == LEN1 || s == DATA;
`endif
  endfunction
  assign acc  = bus.rx_valid && bus.rx_ready;
  assign n    = {bus.rx_data, len[7:0]};
  assign last = bidx == 2'd3 && wcnt == len - 16'd1;
  assign tout = TIMEOUT > 0 && rcv(state) && !acc && to_cnt == TO_LAST;
  // next state from the current state, start and the byte being accepted
  always_comb begin
    nxt = state;
    if (tout) nxt = ERR;
    else
      case (state)
        IDLE, DONE, ERR: nxt = start ? LEN0 : state;
        LEN0: nxt = acc ? LEN1 : LEN0;
        LEN1: nxt = !acc ? LEN1 : n == 16'd0 ? FIN : 32'(n) > DEPTH ? ERR : DATA;
        DATA: nxt = acc && last ? FIN : DATA;
`ifdef LOADER_CHECKSUM_EN
        CHK: nxt = !acc ? CHK : bus.rx_data == csum ? DONE : ERR;
`endif
        default: nxt = IDLE;
      endcase
  end
  // state, byte assembly, memory write pulse and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bus.rx_ready <= 1'b0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= '0;
      bus.im_wdata <= '0;
      cpu_rstn     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      len          <= '0;
      wcnt         <= '0;
      bidx         <= '0;
      sh           <= '0;
      to_cnt       <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      state        <= nxt;
      bus.rx_ready <= rcv(nxt);
      busy         <= rcv(nxt);
      done         <= nxt == DONE;
      err          <= nxt == ERR;
      cpu_rstn     <= state == DONE && nxt == DONE;
      bus.im_we    <= state == DATA && acc && bidx == 2'd3;
      to_cnt       <= rcv(state) && !acc ? to_cnt + 1'b1 : '0;
      if (acc && state == LEN0) len[7:0] <= bus.rx_data;
      if (acc && state == LEN1) len[15:8] <= bus.rx_data;
      if (acc && state == DATA) begin
        sh   <= {bus.rx_data, sh[23:8]};
        bidx <= bidx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        csum <= csum ^ bus.rx_data;
`endif
        if (bidx == 2'd3) begin
          bus.im_addr  <= AW'(wcnt);
          bus.im_wdata <= {bus.rx_data, sh};
          wcnt         <= wcnt + 16'd1;
        end
      end
      if (start && !rcv(state)) begin
        bus.im_addr <= '0;
        wcnt        <= '0;
        bidx        <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum        <= '0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_im_boot_loader.sv
// tb_im_boot_loader: directed and randomized frame loads checked against a frame-level model
module tb_im_boot_loader;
  localparam int AW = 4;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic cpu_rstn, busy, done, err;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] img [64];
  logic [AW+31:0] wr_q [$];
  im_boot_loader_if #(.AW(AW)) bus ();
  im_boot_loader #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .cpu_rstn(cpu_rstn), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.im_we) wr_q.push_back({bus.im_addr, bus.im_wdata});
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    repeat ($urandom_range(0, 3)) tick();
    bus.rx_valid = 1'b1;
    bus.rx_data = b;
    while (!bus.rx_ready && w < 40) begin
      tick();
      w++;
    end
    tick();
    bus.rx_valid = 1'b0;
    chk("accept_wait", 64'(w < 40), 1);
  endtask
  task automatic frame(input int n, input logic [7:0] ck_err, input bit mid_start);
    logic [7:0] q [$];
    logic [7:0] ck = 8'h00;
    bit fit = n <= (1 << AW);
    bit bad = !fit;
    int nw = fit ? n : 0;
    q.push_back(8'(n));
    q.push_back(8'(n >> 8));
    for (int i = 0; i < nw; i++)
      for (int b = 0; b < 4; b++) begin
        q.push_back(img[i][8*b +: 8]);
        ck ^= img[i][8*b +: 8];
      end
`ifdef LOADER_CHECKSUM_EN
    if (fit) q.push_back(ck ^ ck_err);
    bad = bad || ck_err != 8'h00;
`endif
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_ready", bus.rx_ready, 1);
    chk("start_cpu_rstn", cpu_rstn, 0);
    wr_q.delete();
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i]);
      if (mid_start && i == 3) pulse_start();
    end
    chk("end_done", done, 64'(!bad));
    chk("end_err", err, 64'(bad));
    chk("end_busy", busy, 0);
    tick();
    chk("end_cpu_rstn", cpu_rstn, 64'(!bad));
    tick();
    chk("n_writes", wr_q.size(), nw);
    for (int i = 0; i < nw && i < wr_q.size(); i++) chk("write", wr_q[i], {AW'(i), img[i]});
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1);
  end
  initial begin
    bit ready_seen = 1'b0;
    int n;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    #1 rst = 1'b1;
    tick();
    tick();
    chk("reset_outs", {bus.rx_ready, bus.im_we, bus.im_addr, bus.im_wdata, cpu_rstn, busy, done, err}, 0);
    rst = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h55;
    repeat (20) begin
      tick();
      ready_seen |= bus.rx_ready;
    end
    bus.rx_valid = 1'b0;
    chk("idle_ready", ready_seen, 0);
    chk("idle_cpu_rstn", cpu_rstn, 0);
    chk("idle_writes", wr_q.size(), 0);
    img[0] = 32'h00A00513;
    img[1] = 32'h00B00593;
    frame(2, 8'h00, 1'b0);
    frame(17, 8'h00, 1'b0);
    img[0] = 32'h12345678;
    frame(1, 8'h08, 1'b0);
    frame(1, 8'h00, 1'b0);
    pulse_start();
    wr_q.delete();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (TO - 1) tick();
    chk("to_before", err, 0);
    tick();
    chk("to_err", err, 1);
    chk("to_cpu_rstn", cpu_rstn, 0);
    chk("to_ready", bus.rx_ready, 0);
    chk("to_writes", wr_q.size(), 0);
    img[0] = $urandom;
    img[1] = $urandom;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(img[0][7:0]);
    send_byte(img[0][15:8]);
    bus.rx_valid = 1'b1;
    bus.rx_data = img[0][23:16];
    #2 rst = 1'b1;
    #2;
    chk("rst_mid_outs", {bus.rx_ready, bus.im_we, bus.im_addr, bus.im_wdata, cpu_rstn, busy, done, err}, 0);
    bus.rx_valid = 1'b0;
    tick();
    rst = 1'b0;
    img[0] = $urandom;
    frame(1, 8'h00, 1'b0);
    repeat (12) begin
      n = $urandom_range(0, 99) < 15 ? $urandom_range(17, 40) : $urandom_range(0, 16);
      for (int i = 0; i < 64; i++) img[i] = $urandom;
      frame(n, $urandom_range(0, 3) == 0 ? 8'($urandom_range(1, 255)) : 8'h00, 1'($urandom_range(0, 1)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
